// File: rtl/ysyx_25020042_pkg.sv
// Shared definitions for the ysyx_25020042 fetch path: FSM encoding and fixed constants.
package ysyx_25020042_pkg;

  typedef enum logic [1:0] {
    IFU_IDLE = 2'd0,
    IFU_REQ  = 2'd1,
    IFU_RESP = 2'd2
  } ifu_state_e;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;
  localparam logic [31:0] RESET_PC = 32'h8000_0000;

endpackage

// File: rtl/ysyx_25020042_ifu.sv
// Instruction fetch unit: one IDLE -> REQ -> RESP pass per instruction.
// Optional build macro YSYX_25020042_IFU_ALIGN_CHK_EN: a misaligned pc is faulted
// in REQ without issuing a memory request.
//
// state    | meaning
// IFU_IDLE | gap cycle so the next fetch sees the pc advanced by pc_update
// IFU_REQ  | memory read outstanding at pc, waiting for mem_ack
// IFU_RESP | instruction held for decode until inst_ready
module ysyx_25020042_ifu
  import ysyx_25020042_pkg::*;
#(
  parameter int PC_LEN    = 32,
  parameter int INS_BYTES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [PC_LEN-1:0]      pc,
  output logic                   pc_update,
  output logic                   mem_req,
  output logic [PC_LEN-1:0]      mem_addr,
  input  logic                   mem_ack,
  input  logic [8*INS_BYTES-1:0] mem_rdata,
  input  logic                   mem_err,
  output logic                   inst_valid,
  input  logic                   inst_ready,
  output logic [8*INS_BYTES-1:0] inst,
  output logic [PC_LEN-1:0]      inst_pc,
  output logic                   fault
);

  localparam int INST_W = 8 * INS_BYTES;
  localparam logic [INST_W-1:0] NOP_W = INST_W'(NOP_INST);

  ifu_state_e          state_q, state_d;
  logic [INST_W-1:0]   inst_q, inst_d;
  logic [PC_LEN-1:0]   inst_pc_q, inst_pc_d;
  logic                fault_q, fault_d;

  // Next-state, captured-instruction and handshake logic.
  always_comb begin
    state_d    = state_q;
    inst_d     = inst_q;
    inst_pc_d  = inst_pc_q;
    fault_d    = fault_q;
    mem_req    = 1'b0;
    inst_valid = 1'b0;
    pc_update  = 1'b0;
    case (state_q)
      IFU_IDLE: begin
        state_d = IFU_REQ;
      end
      IFU_REQ: begin
`ifdef YSYX_25020042_IFU_ALIGN_CHK_EN
        if (pc[1:0] != 2'b00) begin
          state_d   = IFU_RESP;
          inst_d    = NOP_W;
          inst_pc_d = pc;
          fault_d   = 1'b1;
        end else begin
          mem_req = 1'b1;
          if (mem_ack) begin
            state_d   = IFU_RESP;
            inst_d    = mem_err ? NOP_W : mem_rdata;
            inst_pc_d = pc;
            fault_d   = mem_err;
          end
        end
`else
        mem_req = 1'b1;
        if (mem_ack) begin
          state_d   = IFU_RESP;
          inst_d    = mem_err ? NOP_W : mem_rdata;
          inst_pc_d = pc;
          fault_d   = mem_err;
        end
`endif
      end
      IFU_RESP: begin
        inst_valid = 1'b1;
        if (inst_ready) begin
          pc_update = 1'b1;
          state_d   = IFU_IDLE;
        end
      end
      default: begin
        state_d = IFU_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IFU_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Captured instruction, its address and fault flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inst_q    <= '0;
      inst_pc_q <= '0;
      fault_q   <= 1'b0;
    end else begin
      inst_q    <= inst_d;
      inst_pc_q <= inst_pc_d;
      fault_q   <= fault_d;
    end
  end

  assign mem_addr = pc;
  assign inst     = inst_q;
  assign inst_pc  = inst_pc_q;
  assign fault    = fault_q;

endmodule

// File: tb/tb_ysyx_25020042_ifu.sv
// Bench for ysyx_25020042_ifu: directed scenarios plus randomized fetches, each
// fetch checked cycle by cycle against a transaction-level expectation.
module tb_ysyx_25020042_ifu;
  import ysyx_25020042_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc;
  logic        pc_update;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        mem_err;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        fault;

  int total = 0;
  int bad   = 0;

  ysyx_25020042_ifu #(.PC_LEN(32), .INS_BYTES(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .pc         (pc),
    .pc_update  (pc_update),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .mem_err    (mem_err),
    .inst_valid (inst_valid),
    .inst_ready (inst_ready),
    .inst       (inst),
    .inst_pc    (inst_pc),
    .fault      (fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One complete fetch. Entry/exit point: 1 time unit after the edge that starts
  // the gap cycle. d = cycles before mem_ack, r = cycles before inst_ready.
  task automatic do_fetch(input logic [31:0] p, input int d, input int r,
                          input logic [31:0] rdata, input logic err);
    logic        mis;
    logic [31:0] exp_inst;
    logic        exp_fault;
`ifdef YSYX_25020042_IFU_ALIGN_CHK_EN
    mis = (p[1:0] != 2'b00);
`else
    mis = 1'b0;
`endif
    // gap cycle: a stray ack and ready must be ignored
    pc = p; mem_ack = 1'b1; mem_err = $urandom_range(0, 1) == 1;
    mem_rdata = $urandom; inst_ready = 1'b1;
    #1;
    chk("idle_mem_req", mem_req, 0);
    chk("idle_inst_valid", inst_valid, 0);
    chk("idle_pc_update", pc_update, 0);
    step();
    if (mis) begin
      mem_ack = 1'b1; mem_err = 1'b0; mem_rdata = $urandom; inst_ready = 1'b0;
      #1;
      chk("mis_mem_req", mem_req, 0);
      chk("mis_inst_valid", inst_valid, 0);
      step();
      exp_inst = NOP_INST;
      exp_fault = 1'b1;
    end else begin
      for (int i = 0; i < d; i++) begin
        mem_ack = 1'b0; mem_err = $urandom_range(0, 1) == 1;
        mem_rdata = $urandom; inst_ready = $urandom_range(0, 1) == 1;
        #1;
        chk("wait_mem_req", mem_req, 1);
        chk("wait_mem_addr", mem_addr, p);
        chk("wait_inst_valid", inst_valid, 0);
        chk("wait_pc_update", pc_update, 0);
        step();
      end
      mem_ack = 1'b1; mem_err = err; mem_rdata = rdata; inst_ready = 1'b0;
      #1;
      chk("ack_mem_req", mem_req, 1);
      chk("ack_mem_addr", mem_addr, p);
      step();
      exp_inst = err ? NOP_INST : rdata;
      exp_fault = err;
    end
    for (int j = 0; j < r; j++) begin
      mem_ack = $urandom_range(0, 1) == 1; mem_err = $urandom_range(0, 1) == 1;
      mem_rdata = $urandom; inst_ready = 1'b0;
      #1;
      chk("hold_inst_valid", inst_valid, 1);
      chk("hold_inst", inst, exp_inst);
      chk("hold_inst_pc", inst_pc, p);
      chk("hold_fault", fault, exp_fault);
      chk("hold_pc_update", pc_update, 0);
      chk("hold_mem_req", mem_req, 0);
      step();
    end
    mem_ack = 1'b0; inst_ready = 1'b1;
    #1;
    chk("rdy_inst_valid", inst_valid, 1);
    chk("rdy_pc_update", pc_update, 1);
    chk("rdy_inst", inst, exp_inst);
    chk("rdy_inst_pc", inst_pc, p);
    chk("rdy_fault", fault, exp_fault);
    step();
    inst_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] rp;
    rst = 1'b1; pc = RESET_PC; mem_ack = 1'b0; mem_rdata = '0; mem_err = 1'b0;
    inst_ready = 1'b0;
    #2;
    chk("rst_mem_req", mem_req, 0);
    chk("rst_inst_valid", inst_valid, 0);
    chk("rst_pc_update", pc_update, 0);
    chk("rst_inst", inst, 0);
    chk("rst_inst_pc", inst_pc, 0);
    chk("rst_fault", fault, 0);
    step(); step();
    rst = 1'b0;

    // immediate ack and ready: req in cycle 2, valid and pc_update in cycle 3
    do_fetch(RESET_PC, 0, 0, 32'h0000_0117, 1'b0);
    // slow memory
    do_fetch(32'h8000_0004, 5, 0, 32'h0000_0297, 1'b0);
    // slow decode
    do_fetch(32'h8000_0008, 0, 4, 32'h00a0_0513, 1'b0);
    // bus error
    do_fetch(32'h8000_0010, 1, 1, 32'hdead_beef, 1'b1);

    // reset in the middle of an outstanding request
    pc = 32'h8000_0014; mem_ack = 1'b0; inst_ready = 1'b0;
    step();
    chk("mid_req_mem_req", mem_req, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_mem_req", mem_req, 0);
    chk("mid_rst_inst", inst, 0);
    chk("mid_rst_inst_pc", inst_pc, 0);
    chk("mid_rst_fault", fault, 0);
    step();
    rst = 1'b0;
    // gap cycle of do_fetch drives the late ack
    do_fetch(32'h8000_0014, 2, 1, 32'h0041_0113, 1'b0);

    // misaligned pc: faulted without a request when checking is built in
    do_fetch(32'h8000_0002, 0, 1, 32'h1234_5678, 1'b0);

    for (int k = 0; k < 30; k++) begin
      rp = RESET_PC + 32'($urandom_range(0, 4095) * 4);
      do_fetch(rp, $urandom_range(0, 6), $urandom_range(0, 4), $urandom,
               $urandom_range(0, 3) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ysyx_25020042_ifu.md
YSYX_25020042_IFU -- requirements
Module: ysyx_25020042_ifu

Interface
REQ-001 Parameter PC_LEN, default 32, width of instruction addresses.
REQ-002 Parameter INS_BYTES, default 4, instruction size in bytes; mem_rdata width SHALL be 8*INS_BYTES.
REQ-003 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 pc  in  PC_LEN  current fetch address from the PC register.
REQ-006 pc_update  out  1  one-cycle pulse that advances the PC register (drives its advance/enable).
REQ-007 mem_req  out  1  instruction-memory read request.
REQ-008 mem_addr  out  PC_LEN  read address.
REQ-009 mem_ack  in  1  memory response valid.
REQ-010 mem_rdata  in  8*INS_BYTES  returned instruction word.
REQ-011 mem_err  in  1  bus error, qualified by mem_ack.
REQ-012 inst_valid  out  1  instruction available to decode.
REQ-013 inst_ready  in  1  decode accepts the instruction.
REQ-014 inst  out  8*INS_BYTES  fetched instruction.
REQ-015 inst_pc  out  PC_LEN  address of inst.
REQ-016 fault  out  1  fetch fault flag, qualified by inst_valid.

Function
REQ-017 FSM states: IDLE, REQ, RESP; encoding SHALL come from the shared package.
REQ-018 IDLE: all handshake outputs low; next state REQ unconditionally, so each fetch uses the already-updated pc.
REQ-019 REQ: mem_req=1, mem_addr=pc (combinational from pc); hold until mem_ack=1.
REQ-020 REQ with mem_ack=1: register inst<=mem_rdata, inst_pc<=pc, fault<=mem_err; next state RESP.
REQ-021 mem_ack with mem_err=1: inst SHALL register 32'h0000_0013 (NOP) instead of mem_rdata.
REQ-022 RESP: inst_valid=1; inst, inst_pc, and fault SHALL remain stable until inst_ready=1.
REQ-023 RESP with inst_ready=1: pc_update=1 combinationally in that cycle; next state IDLE.
REQ-024 pc_update SHALL assert only in RESP with inst_ready=1; never more than once per fetched instruction.
REQ-025 Minimum throughput: one instruction per 3 cycles when mem_ack and inst_ready are high on first opportunity.
REQ-026 mem_ack, mem_err, and mem_rdata SHALL be ignored in IDLE and RESP.
REQ-027 inst_ready SHALL be ignored outside RESP.

Reset
REQ-028 On rst=1, state SHALL become IDLE immediately, without waiting for a clock edge.
REQ-029 Reset values: inst=0, inst_pc=0, fault=0; inst_valid=0, mem_req=0, pc_update=0.
REQ-030 Reset during REQ SHALL abandon the request; a late mem_ack after reset release SHALL have no effect (REQ-026).
REQ-031 First mem_req SHALL assert in the second rising edge cycle after rst deasserts (IDLE, then REQ).

Configuration
REQ-032 Macro YSYX_25020042_IFU_ALIGN_CHK_EN defined: in REQ, if pc[1:0]!=0, mem_req SHALL stay 0; next state SHALL be RESP with fault=1, inst=32'h0000_0013, and inst_pc=pc.
REQ-033 Macro undefined: no alignment check; pc SHALL be issued unmodified and fault SHALL reflect mem_err only.

Structure
REQ-034 Shared package ysyx_25020042_pkg SHALL hold:
- FSM state type and encodings
- NOP constant 32'h0000_0013
- reset PC constant 32'h8000_0000
REQ-035 No sub-module; single flat module with one state register block and one output-register block.

Verification
REQ-036 Reset release; pc=32'h8000_0000; mem_ack=1 in first REQ cycle; inst_ready=1 -> mem_req in cycle 2, inst_valid in cycle 3, pc_update pulse in cycle 3.
REQ-037 mem_ack delayed 5 cycles -> mem_req and mem_addr held stable for all 5 cycles; inst=mem_rdata (e.g. 32'h00000297) once ack arrives.
REQ-038 inst_ready low 4 cycles in RESP -> inst, inst_pc, and inst_valid stable; pc_update=0 until ready; then exactly one pulse.
REQ-039 mem_ack=1 with mem_err=1 at pc=32'h8000_0010 -> fault=1, inst=32'h0000_0013, inst_pc=32'h8000_0010.
REQ-040 rst asserted mid-REQ, then mem_ack=1 pulsed after release while in IDLE -> no inst_valid; normal fetch restarts one cycle later.
REQ-041 With YSYX_25020042_IFU_ALIGN_CHK_EN, pc=32'h8000_0002 -> mem_req never asserts; fault=1 with inst_valid; without the macro, mem_addr=32'h8000_0002 is issued.
